// File: rtl/arith_pkg.sv
// Shared encodings for the multi-cycle arithmetic unit: opcodes and FSM states.
package arith_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ITER = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/arith_iter_core.sv
// Iterative datapath shared by shift-add multiply and restoring divide.
// hi/lo present the post-step values so the caller can capture the final step directly.
module arith_iter_core #(
  parameter int unsigned in_width = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  input  logic                mode,   // 0: multiply, 1: divide
  input  logic                step,
  input  logic [in_width-1:0] a,
  input  logic [in_width-1:0] b,
  output logic [in_width-1:0] hi,
  output logic [in_width-1:0] lo
);

  localparam int unsigned W = in_width;

  logic [W-1:0] hi_q, lo_q, b_q;
  logic         mode_q;
  logic [W:0]   x, y, sum;
  logic         cin;
  logic [W-1:0] hi_n, lo_n;

  // One W+1 bit adder: accumulate for mul, trial-subtract (x + ~b + 1) for div.
  always_comb begin
    if (mode_q) begin
      x   = {hi_q, lo_q[W-1]};
      y   = ~{1'b0, b_q};
      cin = 1'b1;
    end else begin
      x   = {1'b0, hi_q};
      y   = lo_q[0] ? {1'b0, b_q} : '0;
      cin = 1'b0;
    end
  end

  assign sum = x + y + {{W{1'b0}}, cin};

  // Divide: the remainder stays below b, so sum[W] is the trial-result sign.
  always_comb begin
    hi_n = sum[W:1];
    lo_n = {sum[0], lo_q[W-1:1]};
    if (mode_q) begin
      hi_n = sum[W] ? x[W-1:0] : sum[W-1:0];
      lo_n = {lo_q[W-2:0], ~sum[W]};
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hi_q   <= '0;
      lo_q   <= '0;
      b_q    <= '0;
      mode_q <= 1'b0;
    end else if (start) begin
      hi_q   <= '0;
      lo_q   <= a;
      b_q    <= b;
      mode_q <= mode;
    end else if (step) begin
      hi_q   <= hi_n;
      lo_q   <= lo_n;
    end
  end

  assign hi = hi_n;
  assign lo = lo_n;

endmodule

// File: rtl/arith_seq_unit.sv
// Multi-cycle arithmetic unit: single-cycle add/sub, iterative mul/div, start/busy/done handshake.
module arith_seq_unit
  import arith_pkg::*;
#(
  parameter int unsigned in_width = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [in_width-1:0]   A,
  input  logic [in_width-1:0]   B,
  input  logic [1:0]            OP,
  input  logic                  enable,
  output logic                  busy,
  output logic [2*in_width-1:0] arith_out,
  output logic                  carry_out,
  output logic                  arith_flag,
  output logic                  div_zero
);

  localparam int unsigned out_width = 2 * in_width;
  localparam int unsigned CntW      = $clog2(in_width) + 1;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [out_width-1:0] out_q, out_d;
  logic                 carry_q, carry_d;
  logic                 dz_q, dz_d;

  logic                 core_start, core_step, core_mode;
  logic [in_width-1:0]  core_hi, core_lo;
  logic [in_width:0]    add_sum, sub_diff;

  assign add_sum   = {1'b0, A} + {1'b0, B};
  assign sub_diff  = {1'b0, A} - {1'b0, B};
  assign core_mode = (OP == OP_DIV);

  arith_iter_core #(
    .in_width (in_width)
  ) u_core (
    .CLK   (CLK),
    .RST   (RST),
    .start (core_start),
    .mode  (core_mode),
    .step  (core_step),
    .a     (A),
    .b     (B),
    .hi    (core_hi),
    .lo    (core_lo)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    out_d      = out_q;
    carry_d    = carry_q;
    dz_d       = dz_q;
    core_start = 1'b0;
    core_step  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (enable) begin
          dz_d    = 1'b0;
          state_d = DONE;
          unique case (OP)
            OP_ADD: begin
              out_d   = {{in_width{1'b0}}, add_sum[in_width-1:0]};
              carry_d = add_sum[in_width];
            end
            OP_SUB: begin
              out_d   = {{in_width{1'b0}}, sub_diff[in_width-1:0]};
              carry_d = sub_diff[in_width];
            end
            OP_MUL: begin
              core_start = 1'b1;
              cnt_d      = CntW'(in_width - 1);
              state_d    = ITER;
            end
            OP_DIV: begin
              if (B == '0) begin
                out_d   = {A, {in_width{1'b1}}};
                carry_d = 1'b0;
                dz_d    = 1'b1;
              end else begin
                core_start = 1'b1;
                cnt_d      = CntW'(in_width - 1);
                state_d    = ITER;
              end
            end
          endcase
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      ITER: begin
        core_step = 1'b1;
        cnt_d     = cnt_q - CntW'(1);
        if (cnt_q == '0) begin
          out_d   = {core_hi, core_lo};
          carry_d = 1'b0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      dz_q    <= dz_d;
    end
  end

  assign busy       = (state_q == ITER);
  assign arith_flag = (state_q == DONE);
  assign arith_out  = out_q;
  assign carry_out  = carry_q;
  assign div_zero   = dz_q;

endmodule
